// File: rtl/ss_cal_variance.sv
// Segment variance: streams RAM words si..ei, accumulates (x - mean)^2, then divides by N.
// Optional macro SS_VAR_ROUND_EN rounds the quotient half-up instead of truncating it.
module ss_cal_variance #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en_var,
  input  logic [ADDR_WIDTH-1:0]   i_addr_si,
  input  logic [ADDR_WIDTH-1:0]   i_addr_ei,
  input  logic [DATA_WIDTH-1:0]   i_mean,
  input  logic [DATA_WIDTH-1:0]   i_data_ram,
  output logic                    o_re_ram,
  output logic [ADDR_WIDTH-1:0]   o_addr_ram,
  output logic [2*DATA_WIDTH-1:0] o_var,
  output logic                    o_busy,
  output logic                    o_err,
  output logic                    o_done
);

  localparam int ACC_W = 2*DATA_WIDTH + ADDR_WIDTH;
  localparam int NW    = ADDR_WIDTH + 1;
  localparam int RW    = ADDR_WIDTH + 1;
  localparam int CW    = $clog2(ACC_W + 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, DIV, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [ADDR_WIDTH-1:0]   ei_reg;
  logic [DATA_WIDTH-1:0]   mean_reg;
  logic [NW-1:0]           n_reg;
  logic [ACC_W-1:0]        acc_reg;
  logic [RW-1:0]           rem_reg;
  logic [CW-1:0]           cnt_reg;
  logic                    rd_d_reg;
  logic [2*DATA_WIDTH-1:0] var_reg;
  logic                    err_reg;

  logic                    start;
  logic                    bad_range;
  logic                    last_read;
  logic [DATA_WIDTH-1:0]   diff;
  logic [2*DATA_WIDTH-1:0] sq;
  logic [RW:0]             rem_shift;
  logic [RW:0]             n_ext;
  logic                    q_bit;
  logic [RW-1:0]           rem_step;
  logic [ACC_W-1:0]        quo_step;
  logic [ACC_W-1:0]        q_final;
  logic [2*DATA_WIDTH-1:0] var_final;
  logic [NW-1:0]           n_calc;

  assign start     = (state_reg == IDLE) && i_en_var;
  assign bad_range = i_addr_ei < i_addr_si;
  assign last_read = addr_reg == ei_reg;
  assign n_calc    = {1'b0, i_addr_ei} - {1'b0, i_addr_si} + NW'(1);

  assign diff = (i_data_ram >= mean_reg) ? (i_data_ram - mean_reg) : (mean_reg - i_data_ram);
  assign sq   = {{DATA_WIDTH{1'b0}}, diff} * {{DATA_WIDTH{1'b0}}, diff};

  // One restoring-division step: the dividend shifts out of acc_reg while quotient bits shift in.
  assign rem_shift = {rem_reg, acc_reg[ACC_W-1]};
  assign n_ext     = {1'b0, n_reg};
  assign q_bit     = rem_shift >= n_ext;
  assign rem_step  = q_bit ? RW'(rem_shift - n_ext) : rem_shift[RW-1:0];
  assign quo_step  = {acc_reg[ACC_W-2:0], q_bit};

`ifdef SS_VAR_ROUND_EN
  logic round_up;
  assign round_up = {rem_step, 1'b0} >= n_ext;
  assign q_final  = quo_step + ACC_W'(round_up);
`else
  assign q_final  = quo_step;
`endif

  // The quotient cannot exceed the largest square, so saturation is only a safety net.
  assign var_final = (|q_final[ACC_W-1:2*DATA_WIDTH]) ? '1 : q_final[2*DATA_WIDTH-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_en_var) state_next = bad_range ? DONE : READ;
      READ:    if (last_read) state_next = DRAIN;
      DRAIN:   state_next = DIV;
      DIV:     if (cnt_reg == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      ei_reg    <= '0;
      mean_reg  <= '0;
      n_reg     <= '0;
      acc_reg   <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      rd_d_reg  <= 1'b0;
      var_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rd_d_reg  <= (state_reg == READ);
      case (state_reg)
        IDLE: begin
          if (start) begin
            err_reg  <= bad_range;
            ei_reg   <= i_addr_ei;
            mean_reg <= i_mean;
            n_reg    <= n_calc;
            acc_reg  <= '0;
            rem_reg  <= '0;
            if (bad_range) var_reg  <= '0;
            else           addr_reg <= i_addr_si;
          end
        end
        READ: begin
          if (!last_read) addr_reg <= addr_reg + ADDR_WIDTH'(1);
          if (rd_d_reg)   acc_reg  <= acc_reg + ACC_W'(sq);
        end
        DRAIN: begin
          acc_reg <= acc_reg + ACC_W'(sq);
          cnt_reg <= CW'(ACC_W);
        end
        DIV: begin
          acc_reg <= quo_step;
          rem_reg <= rem_step;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) var_reg <= var_final;
        end
        default: ;
      endcase
    end
  end

  assign o_re_ram   = (state_reg == READ);
  assign o_addr_ram = addr_reg;
  assign o_var      = var_reg;
  assign o_busy     = (state_reg != IDLE);
  assign o_err      = err_reg;
  assign o_done     = (state_reg == DONE);

endmodule

// File: tb/tb_ss_cal_variance.sv
// Scoreboard bench for ss_cal_variance: driver queues expected results, monitor checks reads and completions.
module tb_ss_cal_variance;
  localparam int DW = 8;
  localparam int AW = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en_var = 1'b0;
  logic [AW-1:0]   addr_si = '0;
  logic [AW-1:0]   addr_ei = '0;
  logic [DW-1:0]   mean = '0;
  logic [DW-1:0]   data_ram;
  logic            re_ram;
  logic [AW-1:0]   addr_ram;
  logic [2*DW-1:0] var_out;
  logic            busy;
  logic            err;
  logic            done;

  always #5 clk = ~clk;

  ss_cal_variance #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en_var(en_var), .i_addr_si(addr_si),
    .i_addr_ei(addr_ei), .i_mean(mean), .i_data_ram(data_ram), .o_re_ram(re_ram),
    .o_addr_ram(addr_ram), .o_var(var_out), .o_busy(busy), .o_err(err), .o_done(done)
  );

  // Synchronous-read RAM model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) if (re_ram) ram_q <= mem[addr_ram];
  assign data_ram = ram_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*DW-1:0] v;
    logic            e;
    int              lat;
    int              start;
    int              nrd;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] addr_q[$];
  exp_t          mon_e;
  int            rd_count = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_count = 0;
    end else begin
      if (re_ram) begin
        if (addr_q.size() == 0) check("unexpected_read", addr_q.size() + 1, 0);
        else                    check("read_addr", addr_ram, addr_q.pop_front());
        rd_count++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", sb.size() + 1, 0);
        end else begin
          mon_e = sb.pop_front();
          $display("txn var=%0d err=%0d latency=%0d reads=%0d", var_out, err, cyc - mon_e.start, rd_count);
          check("var", var_out, mon_e.v);
          check("err", err, mon_e.e);
          check("latency", cyc - mon_e.start, mon_e.lat);
          check("read_count", rd_count, mon_e.nrd);
        end
        rd_count = 0;
      end
    end
  end

  // Called at a negedge; the start is sampled on the following posedge.
  task automatic run(input logic [AW-1:0] si, input logic [AW-1:0] ei, input logic [DW-1:0] m,
                     input logic [2*DW-1:0] v, input logic e, input int lat, input int nrd);
    exp_t x;
    if (!e) for (int a = si; a <= ei; a++) addr_q.push_back(AW'(a));
    x = '{v: v, e: e, lat: lat, start: cyc, nrd: nrd};
    sb.push_back(x);
    en_var  = 1'b1;
    addr_si = si;
    addr_ei = ei;
    mean    = m;
    @(negedge clk);
    en_var  = 1'b0;
    addr_si = AW'($urandom);
    addr_ei = AW'($urandom);
    mean    = DW'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("done_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_re", re_ram, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_var", var_out, 0);
    rst_n = 1'b1;

    // Constant data equal to the mean, start on the first edge after release
    for (int i = 0; i < 4; i++) mem[i] = 8'd10;
    run(0, 3, 10, 0, 0, 28, 4);
    wait_done();

    // {0,2,4,6} about mean 3: squares 9+1+1+9 = 20, /4 = 5
    mem[4] = 0; mem[5] = 2; mem[6] = 4; mem[7] = 6;
    run(4, 7, 3, 5, 0, 28, 4);
    wait_done();

    // Single word; start requests while busy must be ignored
    mem[5] = 200;
    run(5, 5, 100, 10000, 0, 25, 1);
    check("busy_during_run", busy, 1);
    en_var = 1'b1; addr_si = 0; addr_ei = 9; mean = 1;
    repeat (3) @(negedge clk);
    en_var = 1'b0;
    wait_done();

    // Reversed range: error path, no reads, variance forced to 0
    run(10, 3, 7, 0, 1, 1, 0);
    wait_done();
    check("err_hold", err, 1);

    // {0,1,2} mean 0: 5/3 -> 1 truncated, 2 rounded
    mem[0] = 0; mem[1] = 1; mem[2] = 2;
`ifdef SS_VAR_ROUND_EN
    run(0, 2, 0, 2, 0, 27, 3);
`else
    run(0, 2, 0, 1, 0, 27, 3);
`endif
    wait_done();

    // {1,4,8} mean 2: 1+4+36 = 41, /3 = 13 rem 2
    mem[0] = 1; mem[1] = 4; mem[2] = 8;
`ifdef SS_VAR_ROUND_EN
    run(0, 2, 2, 14, 0, 27, 3);
`else
    run(0, 2, 2, 13, 0, 27, 3);
`endif
    wait_done();

    // Full address range, maximum squares
    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'd255;
    run(0, 63, 0, 65025, 0, 88, 64);
    wait_done();

    // Same again, reset in the middle of the division
    run(0, 63, 0, 65025, 0, 88, 64);
    repeat (75) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_re", re_ram, 0);
    check("mid_rst_addr", addr_ram, 0);
    check("mid_rst_var", var_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_done", done, 0);
    sb.delete();
    addr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 63, 0, 65025, 0, 88, 64);
    wait_done();
    check("addr_q_empty", addr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ss_cal_variance.md
SS_CAL_VARIANCE -- requirements
Module: ss_cal_variance

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning RAM word and mean width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, meaning RAM address width.
REQ-003 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_en_var  input  1  start request, sampled in IDLE only.
REQ-006 SHALL have port i_addr_si  input  ADDR_WIDTH  first segment address, inclusive.
REQ-007 SHALL have port i_addr_ei  input  ADDR_WIDTH  last segment address, inclusive.
REQ-008 SHALL have port i_mean  input  DATA_WIDTH  segment mean, from the upstream mean stage.
REQ-009 SHALL have port i_data_ram  input  DATA_WIDTH  RAM read data, valid one cycle after o_re_ram.
REQ-010 SHALL have port o_re_ram  output  1  RAM read enable.
REQ-011 SHALL have port o_addr_ram  output  ADDR_WIDTH  RAM read address.
REQ-012 SHALL have port o_var  output  2*DATA_WIDTH  segment variance.
REQ-013 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port o_err  output  1  high with o_done when i_addr_ei < i_addr_si.
REQ-015 SHALL have port o_done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, READ, DRAIN, DIV, DONE.
REQ-017 SHALL latch si, ei, mean and N = ei - si + 1 (ADDR_WIDTH+1 bits, no wrap) when i_en_var=1 in IDLE, entering READ, or DONE with o_err=1 if ei < si (no RAM reads).
REQ-018 SHALL in READ assert o_re_ram for exactly N consecutive cycles with o_addr_ram = si, si+1, ..., ei; o_re_ram=0 and o_addr_ram holds last value otherwise.
REQ-019 SHALL on each edge after a read cycle add (|i_data_ram - mean|)^2 to an accumulator of ACC_W = 2*DATA_WIDTH+ADDR_WIDTH bits, cleared at start.
REQ-020 SHALL spend one DRAIN cycle to accumulate the last read word, then enter DIV.
REQ-021 SHALL in DIV perform restoring division accumulator / N, one quotient bit per cycle, exactly ACC_W cycles, then enter DONE.
REQ-022 SHALL in DONE assert o_done for one cycle, load o_var with quotient truncated to 2*DATA_WIDTH bits (never overflows since quotient <= (2^DATA_WIDTH-1)^2), return to IDLE.
REQ-023 SHALL give total latency: start edge to o_done cycle = N + ACC_W + 2 cycles (28 for N=4, defaults).
REQ-024 SHALL hold o_var and o_err stable from DONE until the next accepted start; o_err clears on accepted start.
REQ-025 SHALL ignore i_en_var while o_busy=1; inputs other than i_data_ram are don't-care after the start edge.
REQ-026 SHALL on error path set o_var=0.

Reset
REQ-027 SHALL on i_rst_n=0 immediately force IDLE, o_re_ram=0, o_addr_ram=0, o_var=0, o_busy=0, o_err=0, o_done=0, accumulator and divider cleared, including mid-READ or mid-DIV.
REQ-028 SHALL accept a start on the first edge after reset release.

Configuration
REQ-029 SHALL use macro SS_VAR_ROUND_EN: defined -> after division, quotient incremented when 2*remainder >= N (round half up); undefined -> truncated quotient; latency identical both ways.

Verification
REQ-030 SHALL cover: si=0, ei=3, data all 10, mean 10 -> o_var=0, o_err=0, o_done 28 cycles after start, 4 reads at addr 0..3.
REQ-031 SHALL cover: si=4, ei=7, data {0,2,4,6}, mean 3 -> sum 20, o_var=5.
REQ-032 SHALL cover: si=ei=5, data 200, mean 100 -> one read, o_var=10000, o_done 25 cycles after start.
REQ-033 SHALL cover: si=10, ei=3 -> no o_re_ram, o_err=1 with o_done one cycle after start, o_var=0.
REQ-034 SHALL cover: si=0, ei=2, data {0,1,2}, mean 0 -> o_var=1 without SS_VAR_ROUND_EN, 2 with it.
REQ-035 SHALL cover: si=0, ei=63, data all 255, mean 0 -> o_var=65025; repeat with reset asserted mid-DIV -> all outputs 0, next start completes correctly.
